i2c_mem_bridge: RTL

I2C_MEM_BRIDGE -- requirements
Module: i2c_mem_bridge

---
 rtl/i2c_bridge_pkg.sv | 20 ++
 rtl/i2c_bridge_fifo.sv | 59 +++++
 rtl/i2c_mem_bridge.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/i2c_bridge_pkg.sv
// i2c_bridge_pkg: shared widths, bridge FSM state encoding and the layout of
// one posted-write FIFO entry.
package i2c_bridge_pkg;

  localparam int I2C_ADDR_W = 11;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RESP
  } bridge_state_t;

  typedef struct packed {
    logic [I2C_ADDR_W-1:0] addr;
    logic [I2C_DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/i2c_bridge_fifo.sv
// i2c_bridge_fifo: synchronous write-post FIFO with a registered occupancy
// count. It exposes the head entry and the entry behind it so that the bridge
// can chain back-to-back writes without an idle cycle. A push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module i2c_bridge_fifo
  import i2c_bridge_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  fifo_entry_t       push_data,
  input  logic              pop,
  output fifo_entry_t       head,
  output fifo_entry_t       second,
  output logic              push_accepted,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  fifo_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;

  assign full          = (count == CNT_W'(DEPTH));
  assign empty         = (count == '0);
  assign pop_ok        = pop && !empty;
  assign push_accepted = push && (!full || pop_ok);
  assign head          = mem[rd_ptr];
  assign second        = mem[rd_ptr + PTR_W'(1)];

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy 0..DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_accepted) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_accepted, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; validity is carried entirely by count.
  always_ff @(posedge clock) begin
    if (!reset && push_accepted) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/i2c_mem_bridge.sv
// i2c_mem_bridge: turns I2C slave transfer strobes into single-beat memory
// requests. Writes are posted through a FIFO; one read may be pending at a
// time and is only issued once every earlier posted write has completed.
// Optional feature: define I2C_BRIDGE_ERRCNT_EN to add the err_cnt output,
// a saturating count of dropped transfers.
module i2c_mem_bridge
  import i2c_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  i2c_xfc,
  input  logic                  i2c_op,
  input  logic [I2C_ADDR_W-1:0] i2c_addr_out,
  input  logic [I2C_DATA_W-1:0] i2c_data_out,
  output logic [I2C_DATA_W-1:0] i2c_rdata,
  output logic                  i2c_xfc_read,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [I2C_ADDR_W-1:0] mem_addr,
  output logic [I2C_DATA_W-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [I2C_DATA_W-1:0] mem_rdata,
  output logic                  busy,
  output logic                  fifo_full,
  output logic                  ovf_err
`ifdef I2C_BRIDGE_ERRCNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  bridge_state_t         state;
  logic                  pending_valid;
  logic [I2C_ADDR_W-1:0] pending_addr;

  logic                  wr_strobe;
  logic                  rd_strobe;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic                  push_accepted;
  logic                  drop;
  logic [CNT_W-1:0]      fifo_count;
  fifo_entry_t           push_entry;
  fifo_entry_t           head_entry;
  fifo_entry_t           second_entry;
  fifo_entry_t           next_entry;

  assign wr_strobe       = i2c_xfc && !i2c_op;
  assign rd_strobe       = i2c_xfc && i2c_op;
  assign fifo_pop        = (state == ST_WR) && mem_ack;
  assign push_entry.addr = i2c_addr_out;
  assign push_entry.data = i2c_data_out;
  assign drop            = (wr_strobe && !push_accepted) || (rd_strobe && pending_valid);
  assign busy            = (state != ST_IDLE);

  // With one entry left and a same-cycle push, the follow-on write is the incoming one.
  assign next_entry = (fifo_count > CNT_W'(1)) ? second_entry : push_entry;

  i2c_bridge_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock         (Clock),
    .reset         (Reset),
    .push          (wr_strobe),
    .push_data     (push_entry),
    .pop           (fifo_pop),
    .head          (head_entry),
    .second        (second_entry),
    .push_accepted (push_accepted),
    .full          (fifo_full),
    .empty         (fifo_empty),
    .count         (fifo_count)
  );

  // Bridge FSM: captures reads, sequences memory requests and drives all registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= ST_IDLE;
      pending_valid <= 1'b0;
      pending_addr  <= '0;
      ovf_err       <= 1'b0;
      i2c_rdata     <= '0;
      i2c_xfc_read  <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else begin
      i2c_xfc_read <= 1'b0;
      if (drop) ovf_err <= 1'b1;
      if (rd_strobe && !pending_valid) begin
        pending_valid <= 1'b1;
        pending_addr  <= i2c_addr_out;
      end

      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state     <= ST_WR;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= head_entry.addr;
            mem_wdata <= head_entry.data;
          end else if (pending_valid) begin
            state    <= ST_RD;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pending_addr;
          end else if (push_accepted) begin
            state     <= ST_WR;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= i2c_addr_out;
            mem_wdata <= i2c_data_out;
          end else if (rd_strobe) begin
            state    <= ST_RD;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= i2c_addr_out;
          end
        end

        ST_WR: begin
          if (mem_ack) begin
            if ((fifo_count > CNT_W'(1)) || push_accepted) begin
              mem_addr  <= next_entry.addr;
              mem_wdata <= next_entry.data;
            end else begin
              state   <= ST_IDLE;
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
            end
          end
        end

        ST_RD: begin
          if (mem_ack) begin
            state        <= ST_RESP;
            mem_req      <= 1'b0;
            i2c_rdata    <= mem_rdata;
            i2c_xfc_read <= 1'b1;
          end
        end

        ST_RESP: begin
          pending_valid <= 1'b0;
          state         <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef I2C_BRIDGE_ERRCNT_EN
  // Saturating count of dropped write and read strobes.
  always_ff @(posedge Clock) begin
    if (Reset)                          err_cnt <= '0;
    else if (drop && err_cnt != 8'hFF)  err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule
